// File: rtl/arduino_rx.sv
// 8N1 serial receiver for the Arduino return link. It presents each byte with a
// valid stop bit and its one-hot note decode, and flags framing errors.
module arduino_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arduino_in,
    output logic [7:0] dado,
    output logic [6:0] notas,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [2:0] db_estado
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        INICIO = 3'd1,
        DADOS  = 3'd2,
        PARADA = 3'd3,
        ESPERA = 3'd4
    } estado_t;

    estado_t          estado;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_ciclo;
    logic [2:0]       cnt_bit;
    logic [7:0]       shift;

    // Byte codes 1..7 select one note; every other code lights nothing.
    function automatic logic [6:0] decode_nota(input logic [7:0] b);
        logic [6:0] n;
        case (b)
            8'd1:    n = 7'b0000001;
            8'd2:    n = 7'b0000010;
            8'd3:    n = 7'b0000100;
            8'd4:    n = 7'b0001000;
            8'd5:    n = 7'b0010000;
            8'd6:    n = 7'b0100000;
            8'd7:    n = 7'b1000000;
            default: n = 7'b0000000;
        endcase
        return n;
    endfunction

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= arduino_in;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: pronto/erro default low so they only pulse for one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= OCIOSO;
            cnt_ciclo <= '0;
            cnt_bit   <= '0;
            shift     <= '0;
            dado      <= '0;
            notas     <= '0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (!rx_s) begin
                        estado    <= INICIO;
                        cnt_ciclo <= '0;
                    end
                end
                INICIO: begin
                    if (cnt_ciclo == CNT_HALF_END) begin
                        cnt_ciclo <= '0;
                        cnt_bit   <= '0;
                        // A high level at mid start bit was only a glitch.
                        estado    <= rx_s ? OCIOSO : DADOS;
                    end else begin
                        cnt_ciclo <= cnt_ciclo + CNT_W'(1);
                    end
                end
                DADOS: begin
                    if (cnt_ciclo == CNT_BIT_END) begin
                        cnt_ciclo <= '0;
                        shift     <= {rx_s, shift[7:1]};
                        cnt_bit   <= cnt_bit + 3'd1;
                        if (cnt_bit == 3'd7) begin
                            estado <= PARADA;
                        end
                    end else begin
                        cnt_ciclo <= cnt_ciclo + CNT_W'(1);
                    end
                end
                PARADA: begin
                    if (cnt_ciclo == CNT_BIT_END) begin
                        cnt_ciclo <= '0;
                        if (rx_s) begin
                            dado   <= shift;
                            notas  <= decode_nota(shift);
                            pronto <= 1'b1;
                            estado <= OCIOSO;
                        end else begin
                            erro   <= 1'b1;
                            estado <= ESPERA;
                        end
                    end else begin
                        cnt_ciclo <= cnt_ciclo + CNT_W'(1);
                    end
                end
                ESPERA: begin
                    // Hold off until the break ends so it is not taken as a start bit.
                    if (rx_s) begin
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign ocupado   = (estado != OCIOSO);
    assign db_estado = estado;

endmodule

// File: doc/arduino_rx.md
Name: arduino_rx

Overview:
- Serial receiver for the link from the Arduino back into the game circuit. It is the counterpart to the single-bit `arduino_out` transmit line.
- Decodes 8N1 UART frames carrying note/button codes sent by the Arduino.
- Presents each accepted byte and a 7-bit one-hot note vector, with the same encoding as `botoes`/`leds`, to the data path. A one-cycle `pronto` pulse marks each accepted byte.
- Sits beside the fluxo_dados block. The unidade_controle consumes `pronto`/`erro` like a `jogada` event.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit falling edge to the start-bit centre sample.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- arduino_in  input  1  serial line from the Arduino. Idle high. Asynchronous to clock.
- dado  output  8  last byte received with a valid stop bit.
- notas  output  7  one-hot note decode of dado.
- pronto  output  1  one-cycle pulse: dado/notas just updated.
- erro  output  1  one-cycle pulse: framing error (stop bit sampled 0).
- ocupado  output  1  high whenever the FSM is not in OCIOSO.
- db_estado  output  3  current FSM state code, for estado7seg.

Behaviour:
- Input synchronisation:
  - arduino_in passes through a 2-FF synchroniser. Both flops reset to 1.
  - All logic below uses only the synchronised signal rx_s.
- Reset (reset=0, asynchronous):
  - State → OCIOSO. Bit counter = 0, cycle counter = 0, shift register = 0.
  - dado = 8'h00, notas = 7'b0, pronto = 0, erro = 0, ocupado = 0.
  - Reset mid-frame aborts the frame: no pronto/erro, and dado keeps its reset value.
- FSM states and codes:
  - OCIOSO = 0, INICIO = 1, DADOS = 2, PARADA = 3, ESPERA = 4.
- OCIOSO:
  - If rx_s == 0: go to INICIO and clear the cycle counter.
- INICIO:
  - Count HALF_BIT cycles, then sample rx_s.
  - If 0: go to DADOS, clear the cycle counter and bit counter.
  - If 1: treat it as a glitch and return to OCIOSO with no pulse.
- DADOS:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first (bit 0 received first).
  - After the 8th sample, go to PARADA.
- PARADA:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - If 1: on the next clock edge, dado ← shift register and notas ← decode. pronto = 1 for exactly that one cycle. Go to OCIOSO.
  - If 0: erro = 1 for one cycle. dado and notas are unchanged. Go to ESPERA.
- ESPERA:
  - Stay until rx_s == 1, then go to OCIOSO.
  - This prevents a held-low break from being re-read as a new start bit.
- Note decode:
  - If the byte is 1..7: notas = 1 << (byte − 1).
  - Any other value (0, or ≥ 8): notas = 0.
  - notas is registered together with dado, so it always matches dado.
- pronto and erro are never high in the same cycle. Both are low in all states except the single cycle after a PARADA sample.
- ocupado = (state != OCIOSO). It is combinational from the state register.
- Timing:
  - Latency from the start-bit falling edge on arduino_in to the pronto cycle is 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles, ±1.
  - Back-to-back frames: a start bit immediately following the stop bit is detected, because OCIOSO is re-entered one cycle after the PARADA sample.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT).
  - Bit counter is 3 bits and wraps to 0 after bit 7. It is never read outside DADOS.

Test Plan:
- CLKS_PER_BIT=8. Send byte 0x03 with stop=1 → dado=0x03, notas=7'b0000100, pronto high exactly 1 cycle, erro never high, ocupado returns to 0.
- Pulse arduino_in low for 2 cycles only (< HALF_BIT) → FSM returns to OCIOSO, no pronto/erro, dado unchanged.
- Send 0x05 with stop bit forced 0, then hold the line low 40 cycles, then high → erro 1 cycle, dado/notas unchanged. db_estado=4 while low, then 0 once high, with no spurious frame.
- Send 0x55 → dado=0x55, notas=0, pronto 1 cycle. Then send 0x07 → notas=7'b1000000.
- Two back-to-back frames 0x01 then 0x02 with no idle gap → two pronto pulses, with final dado=0x02 and notas=7'b0000010.
- Drive reset=0 during bit 4 of a frame, release it, then send 0x06 → dado stays 0x00 until the new frame completes, then dado=0x06 and notas=7'b0100000.
